// File: rtl/mem_fifo_pkg.sv
// Shared types and constants for the memory-stage access FIFO.
// Widths of address, latency and timestamp fields live here.
package mem_fifo_pkg;

  localparam int ADDR_W  = 5;
  localparam int DELAY_W = 10;
  localparam int TIME_W  = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TIME_W-1:0] in_time;
    logic [TIME_W-1:0] out_time;
  } mem_req_t;

  // Wraps modulo 2^TIME_W on purpose.
  function automatic logic [TIME_W-1:0] due_time(
    input logic [TIME_W-1:0]  now,
    input logic [DELAY_W-1:0] dly
  );
    return now + TIME_W'(dly);
  endfunction

endpackage

// File: rtl/mem_fifo_ptr_ctrl.sv
// Pointer, occupancy and push/pop qualification for mem_access_fifo.
// MEM_FIFO_ALMOST_FULL_EN: full flag raised one slot early.
module mem_fifo_ptr_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          push_req_i,
  input  logic          pop_req_i,
  output logic          push_o,
  output logic          pop_o,
  output logic [AW-1:0] wr_ptr_o,
  output logic [AW-1:0] rd_ptr_o,
  output logic          empty_o,
  output logic          full_o
);

  logic [AW:0]   occ_q, occ_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          real_full;

  assign real_full = (occ_q == (AW+1)'(DEPTH));
  assign empty_o   = (occ_q == '0);
  assign push_o    = push_req_i & ~real_full;
  assign pop_o     = pop_req_i & ~empty_o;

  always_comb begin
    wr_d  = wr_q + AW'(push_o);
    rd_d  = rd_q + AW'(pop_o);
    occ_d = occ_q + (AW+1)'(push_o)
                  - (AW+1)'(pop_o);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      occ_q <= occ_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

`ifdef MEM_FIFO_ALMOST_FULL_EN
  assign full_o = (occ_q >= (AW+1)'(DEPTH-1));
`else
  assign full_o = real_full;
`endif

  assign wr_ptr_o = wr_q;
  assign rd_ptr_o = rd_q;

endmodule

// File: rtl/mem_access_fifo.sv
// Time-stamped pending-access queue for the SIMD memory stage.
// MEM_FIFO_ALMOST_FULL_EN: see mem_fifo_ptr_ctrl.
module mem_access_fifo
  import mem_fifo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               i,
  input  logic [ADDR_W-1:0]  RAM_Addr_i,
  input  logic [DELAY_W-1:0] Delay,
  input  logic [TIME_W-1:0]  count,
  input  logic               o,
  input  logic               FIFOIn,
  output logic [ADDR_W-1:0]  RAM_Addr_o,
  output logic [TIME_W-1:0]  HeadOutTime,
  output logic [TIME_W-1:0]  HeadInTime,
  output logic               full
);

  localparam int AW = $clog2(DEPTH);

  mem_req_t [DEPTH-1:0] mem_q;
  mem_req_t             req_d;
  mem_req_t             head;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 push, pop, empty;

  mem_fifo_ptr_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ptr (
    .clk        (clk),
    .rst_ni     (reset),
    .push_req_i (i & FIFOIn & ~stall_i),
    .pop_req_i  (o),
    .push_o     (push),
    .pop_o      (pop),
    .wr_ptr_o   (wr_ptr),
    .rd_ptr_o   (rd_ptr),
    .empty_o    (empty),
    .full_o     (full)
  );

  always_comb begin
    req_d.addr     = RAM_Addr_i;
    req_d.in_time  = count;
    req_d.out_time = due_time(count, Delay);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
    end else if (push) begin
      mem_q[wr_ptr] <= req_d;
    end
  end

  // pop only moves rd_ptr; the slot is simply overwritten later
  assign head = empty ? '0 : mem_q[rd_ptr];

  assign RAM_Addr_o  = head.addr;
  assign HeadInTime  = head.in_time;
  assign HeadOutTime = head.out_time;

endmodule

// File: tb/tb_mem_access_fifo.sv
// Randomised and directed bench for mem_access_fifo.
// Queue-based reference model checked on every falling edge.
module tb_mem_access_fifo;

  localparam int DEPTH = 8;

  logic        clk = 0;
  logic        reset = 0;
  logic        stall_i = 0;
  logic        i = 0;
  logic [4:0]  RAM_Addr_i = 0;
  logic [9:0]  Delay = 0;
  logic [15:0] count = 0;
  logic        o = 0;
  logic        FIFOIn = 0;
  logic [4:0]  RAM_Addr_o;
  logic [15:0] HeadOutTime;
  logic [15:0] HeadInTime;
  logic        full;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int addr;
    int tin;
    int tout;
  } ent_t;

  ent_t q[$];

  mem_access_fifo #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall_i     (stall_i),
    .i           (i),
    .RAM_Addr_i  (RAM_Addr_i),
    .Delay       (Delay),
    .count       (count),
    .o           (o),
    .FIFOIn      (FIFOIn),
    .RAM_Addr_o  (RAM_Addr_o),
    .HeadOutTime (HeadOutTime),
    .HeadInTime  (HeadInTime),
    .full        (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // reference model: update on each active edge
  always @(posedge clk) begin
    if (reset) begin
      automatic int  n  = q.size();
      automatic bit  ps = i && FIFOIn && !stall_i && (n < DEPTH);
      automatic bit  pp = o && (n > 0);
      automatic ent_t e;
      e.addr = int'(RAM_Addr_i);
      e.tin  = int'(count);
      e.tout = (int'(count) + int'(Delay)) % 65536;
      if (pp) void'(q.pop_front());
      if (ps) q.push_back(e);
    end
  end

  always @(negedge reset) q.delete();

  // compare process
  always @(negedge clk) begin
    if (reset) begin
      automatic int n = q.size();
      automatic int ea = (n > 0) ? q[0].addr : 0;
      automatic int ei = (n > 0) ? q[0].tin : 0;
      automatic int eo = (n > 0) ? q[0].tout : 0;
      automatic int ef;
`ifdef MEM_FIFO_ALMOST_FULL_EN
      ef = (n >= DEPTH - 1) ? 1 : 0;
`else
      ef = (n == DEPTH) ? 1 : 0;
`endif
      chk("m_addr", int'(RAM_Addr_o), ea);
      chk("m_tin", int'(HeadInTime), ei);
      chk("m_tout", int'(HeadOutTime), eo);
      chk("m_full", int'(full), ef);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    count = count + 16'd1;
  endtask

  task automatic idle();
    i = 0; FIFOIn = 0; o = 0; stall_i = 0;
  endtask

  task automatic push(input int a, input int d);
    i = 1; FIFOIn = 1; o = 0; stall_i = 0;
    RAM_Addr_i = 5'(a);
    Delay = 10'(d);
    cyc();
    idle();
  endtask

  task automatic pop1();
    idle();
    o = 1;
    cyc();
    idle();
  endtask

  task automatic zero_chk(input string nm);
    chk({nm, "_addr"}, int'(RAM_Addr_o), 0);
    chk({nm, "_tin"}, int'(HeadInTime), 0);
    chk({nm, "_tout"}, int'(HeadOutTime), 0);
    chk({nm, "_full"}, int'(full), 0);
  endtask

  initial begin
    repeat (3) cyc();
    zero_chk("rst");
    reset = 1;
    cyc();

    // 1: basic push
    count = 16'd4;
    push(1, 10);
    chk("t1_addr", int'(RAM_Addr_o), 1);
    chk("t1_tin", int'(HeadInTime), 4);
    chk("t1_tout", int'(HeadOutTime), 14);
    chk("t1_full", int'(full), 0);
    pop1();
    zero_chk("t1_empty");

    // 2: fill, overflow, drain in order
    for (int k = 0; k < DEPTH; k++) push(k, k + 1);
    chk("t2_full", int'(full), 1);
    push(31, 3);
    chk("t2_full9", int'(full), 1);
    for (int k = 0; k < DEPTH; k++) begin
      chk("t2_order", int'(RAM_Addr_o), k);
      pop1();
    end
    zero_chk("t2_empty");

    // 3: due-time wrap
    count = 16'hFFFA;
    push(3, 10);
    chk("t3_tout", int'(HeadOutTime), 16'h0004);
    chk("t3_tin", int'(HeadInTime), 16'hFFFA);
    pop1();

    // 4: stall blocks push, not pop
    push(9, 2);
    stall_i = 1; i = 1; FIFOIn = 1;
    RAM_Addr_i = 5'd20;
    repeat (5) cyc();
    chk("t4_head", int'(RAM_Addr_o), 9);
    o = 1;
    cyc();
    idle();
    zero_chk("t4_pop");

    // 5: push+pop on full edge
    for (int k = 0; k < DEPTH; k++) push(k, 5);
    i = 1; FIFOIn = 1; o = 1;
    RAM_Addr_i = 5'd25;
    cyc();
    idle();
`ifndef MEM_FIFO_ALMOST_FULL_EN
    chk("t5_full", int'(full), 0);
`endif
    for (int k = 1; k < DEPTH; k++) begin
      chk("t5_order", int'(RAM_Addr_o), k);
      pop1();
    end
    zero_chk("t5_empty");

    // 6: async reset mid-stream
    push(11, 1); push(12, 2); push(13, 3);
    #1 reset = 0;
    #1 zero_chk("t6_rst");
    cyc();
    reset = 1;
    cyc();
    push(17, 4);
    chk("t6_head", int'(RAM_Addr_o), 17);
    pop1();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      i = 1'($urandom_range(0, 1));
      FIFOIn = ($urandom_range(0, 3) != 0);
      stall_i = ($urandom_range(0, 4) == 0);
      o = ($urandom_range(0, 2) == 0);
      RAM_Addr_i = 5'($urandom);
      Delay = 10'($urandom);
      if ($urandom_range(0, 40) == 0) count = 16'($urandom);
      cyc();
    end
    idle();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
